// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between the LED pattern sequencer and its controller.
// The master drives the run controls; the slave (the sequencer) returns the address and pulses.
interface led_pattern_sequencer_if #(
  parameter int ADDR_WIDTH_BITS = 4,
  parameter int PRESCALE_WIDTH  = 24
);
  logic                       enable_i;
  logic [1:0]                 mode_i;
  logic [PRESCALE_WIDTH-1:0]  prescale_i;
  logic [ADDR_WIDTH_BITS-1:0] start_addr_i;
  logic [ADDR_WIDTH_BITS-1:0] end_addr_i;
  logic                       step_i;
  logic [ADDR_WIDTH_BITS-1:0] addr_o;
  logic                       step_o;
  logic                       wrap_o;
  logic                       busy_o;

  modport master (
    output enable_i, mode_i, prescale_i, start_addr_i, end_addr_i, step_i,
    input  addr_o, step_o, wrap_o, busy_o
  );

  modport slave (
    input  enable_i, mode_i, prescale_i, start_addr_i, end_addr_i, step_i,
    output addr_o, step_o, wrap_o, busy_o
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Walks a programmable address window (up, down, ping-pong or hold) at a prescaled
// rate, with manual single-stepping while idle. Drives the pattern memory address.
module led_pattern_sequencer #(
  parameter int ADDR_WIDTH_BITS = 4,
  parameter int PRESCALE_WIDTH  = 24
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  led_pattern_sequencer_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_WIDTH_BITS-1:0] ADDR_ONE = {{(ADDR_WIDTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0]  CNT_ONE  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0]  CNT_ZERO = {PRESCALE_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH_BITS-1:0] ADDR_ZERO = {ADDR_WIDTH_BITS{1'b0}};

  state_t                     state_q;
  logic [ADDR_WIDTH_BITS-1:0] addr_q, addr_d;
  logic                       dir_q, dir_d;   // 0 = moving up, 1 = moving down
  logic [PRESCALE_WIDTH-1:0]  cnt_q;
  logic                       step_q, step_d;
  logic                       wrap_q, wrap_d;
  logic                       busy_q;

  logic [ADDR_WIDTH_BITS-1:0] lo_s, hi_s;
  logic                       out_of_window_s;

  assign lo_s = bus.start_addr_i;
  assign hi_s = bus.end_addr_i;
  assign out_of_window_s = (addr_q < lo_s) || (addr_q > hi_s);

  // Result of one advance from the current position; only committed on an advancing edge.
  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.mode_i == 2'b11) begin
      addr_d = addr_q;
    end else if (lo_s > hi_s) begin
      addr_d = lo_s;
    end else begin
      step_d = 1'b1;
      case (bus.mode_i)
        2'b00: begin
          if (out_of_window_s || addr_q == hi_s) begin
            addr_d = lo_s;
            wrap_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
        2'b01: begin
          if (out_of_window_s || addr_q == lo_s) begin
            addr_d = hi_s;
            wrap_d = 1'b1;
          end else begin
            addr_d = addr_q - ADDR_ONE;
          end
        end
        2'b10: begin
          if (out_of_window_s) begin
            addr_d = dir_q ? hi_s : lo_s;
            wrap_d = 1'b1;
          end else if (lo_s == hi_s) begin
            addr_d = lo_s;
            wrap_d = 1'b1;
          end else if (!dir_q) begin
            if (addr_q == hi_s) begin
              addr_d = hi_s - ADDR_ONE;
              dir_d  = 1'b1;
              wrap_d = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end else begin
            if (addr_q == lo_s) begin
              addr_d = lo_s + ADDR_ONE;
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end else begin
              addr_d = addr_q - ADDR_ONE;
            end
          end
        end
        default: begin
          addr_d = addr_q;
          step_d = 1'b0;
        end
      endcase
    end
  end

  // IDLE/RUN sequencer with prescaler and registered outputs.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= ADDR_ZERO;
      dir_q   <= 1'b0;
      cnt_q   <= CNT_ZERO;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q  <= CNT_ZERO;
          step_q <= 1'b0;
          wrap_q <= 1'b0;
          if (bus.enable_i) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            addr_q  <= (bus.mode_i == 2'b01) ? hi_s : lo_s;
            dir_q   <= (bus.mode_i == 2'b01);
          end else if (bus.step_i) begin
            addr_q <= addr_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.enable_i) begin
            // A step falling due on the disabling edge is intentionally dropped.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= CNT_ZERO;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
          end else if (cnt_q >= bus.prescale_i) begin
            cnt_q  <= CNT_ZERO;
            addr_q <= addr_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
          end else begin
            cnt_q  <= cnt_q + CNT_ONE;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr_o = addr_q;
  assign bus.step_o = step_q;
  assign bus.wrap_o = wrap_q;
  assign bus.busy_o = busy_q;
endmodule
